sdram_protocol_checker: RTL and testbench

SDRAM_PROTOCOL_CHECKER -- requirements
Module: sdram_protocol_checker

---
 rtl/sdram_protocol_checker.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_protocol_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_protocol_checker.sv
// Passive SDRAM command-bus monitor: tracks per-bank open state and timing, and records
// protocol violations. Define SDRAM_CHECKER_REFRESH_EN to add the refresh-interval (tREFI) check.
module sdram_protocol_checker #(
    parameter int W_BANKSEL = 2,
    parameter int W_ADDR    = 13,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_RAS     = 5,
    parameter int T_RFC     = 8,
    parameter int BURST_LEN = 8,
    parameter int T_REFI    = 780
) (
    input  logic                 clk_sys,
    input  logic                 rst_n_por,
    input  logic                 sdram_clke,
    input  logic                 sdram_cs_n,
    input  logic                 sdram_ras_n,
    input  logic                 sdram_cas_n,
    input  logic                 sdram_we_n,
    input  logic [W_BANKSEL-1:0] sdram_ba,
    input  logic [W_ADDR-1:0]    sdram_a,
    input  logic                 clr_errors,
    output logic [7:0]           err_flags,
    output logic [15:0]          err_count,
    output logic                 first_err_valid,
    output logic [2:0]           first_err_code
);

    localparam int NB = 1 << W_BANKSEL;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    cmd_e        cmd;
    logic        a10;
    logic        addr_unused;
    logic [7:0]  viol;
    logic        any_viol;

    logic [NB-1:0] open_q, open_d;
    logic [NB-1:0] ap_q, ap_d;
    logic [7:0]    act_cnt_q [NB];
    logic [7:0]    act_cnt_d [NB];
    logic [7:0]    pre_cnt_q [NB];
    logic [7:0]    pre_cnt_d [NB];
    logic [7:0]    ref_cnt_q, ref_cnt_d;

    logic [7:0]    flags_q, flags_d;
    logic [15:0]   count_q, count_d;
    logic          fv_q, fv_d;
    logic [2:0]    code_q, code_d;
    logic [15:0]   count_base;
    logic          fv_base;
    logic          found;

`ifdef SDRAM_CHECKER_REFRESH_EN
    localparam int W_TMR = $clog2(T_REFI + 1);
    logic [W_TMR-1:0] timer_q, timer_d;
    logic             fired_q, fired_d;
`endif

    assign a10         = sdram_a[10];
    assign addr_unused = ^{sdram_a[W_ADDR-1:11], sdram_a[9:0]};

    always_comb begin
        cmd = CMD_NOP;
        if (sdram_clke && !sdram_cs_n) begin
            cmd = cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
        end
    end

    // Counters hold (cycles since event - 1), hence the "+1" in every timing compare.
    always_comb begin
        viol      = '0;
        open_d    = open_q;
        ap_d      = ap_q;
        ref_cnt_d = sat_inc(ref_cnt_q);
        for (int unsigned b = 0; b < NB; b++) begin
            act_cnt_d[b] = sat_inc(act_cnt_q[b]);
            pre_cnt_d[b] = sat_inc(pre_cnt_q[b]);
        end

        if (cmd != CMD_NOP && (int'(ref_cnt_q) + 1) < T_RFC) viol[6] = 1'b1;

        case (cmd)
            CMD_ACT: begin
                if (open_q[sdram_ba]) viol[0] = 1'b1;
                if ((int'(pre_cnt_q[sdram_ba]) + 1) <
                    (ap_q[sdram_ba] ? (T_RP + BURST_LEN) : T_RP)) viol[3] = 1'b1;
                open_d[sdram_ba]    = 1'b1;
                act_cnt_d[sdram_ba] = '0;
            end
            CMD_RD, CMD_WR: begin
                if (!open_q[sdram_ba]) viol[1] = 1'b1;
                if ((int'(act_cnt_q[sdram_ba]) + 1) < T_RCD) viol[2] = 1'b1;
                if (a10) begin
                    open_d[sdram_ba]    = 1'b0;
                    pre_cnt_d[sdram_ba] = '0;
                    ap_d[sdram_ba]      = 1'b1;
                end
            end
            CMD_PRE: begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if ((a10 || sdram_ba == W_BANKSEL'(b)) && open_q[b]) begin
                        if ((int'(act_cnt_q[b]) + 1) < T_RAS) viol[4] = 1'b1;
                        open_d[b]    = 1'b0;
                        pre_cnt_d[b] = '0;
                        ap_d[b]      = 1'b0;
                    end
                end
            end
            CMD_REF, CMD_MRS: begin
                if (|open_q) viol[5] = 1'b1;
                if (cmd == CMD_REF) ref_cnt_d = '0;
            end
            default: ;
        endcase

`ifdef SDRAM_CHECKER_REFRESH_EN
        timer_d = timer_q;
        fired_d = fired_q;
        if (timer_q != W_TMR'(T_REFI)) timer_d = timer_q + 1'b1;
        if (timer_q == W_TMR'(T_REFI) && !fired_q) begin
            viol[7] = 1'b1;
            fired_d = 1'b1;
        end
        if (cmd == CMD_REF) begin
            timer_d = '0;
            fired_d = 1'b0;
        end
`endif
    end

    // A clear in the same cycle as a violation acts first, so the new violation is recorded fresh.
    always_comb begin
        any_viol   = |viol;
        flags_d    = (clr_errors ? 8'h00 : flags_q) | viol;
        count_base = clr_errors ? 16'h0000 : count_q;
        fv_base    = clr_errors ? 1'b0 : fv_q;
        count_d    = count_base;
        fv_d       = fv_base;
        code_d     = code_q;
        found      = 1'b0;
        if (any_viol && count_base != 16'hFFFF) count_d = count_base + 16'd1;
        if (any_viol && !fv_base) begin
            fv_d = 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
                if (viol[i] && !found) begin
                    code_d = 3'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n_por) begin
        if (!rst_n_por) begin
            open_q    <= '0;
            ap_q      <= '0;
            ref_cnt_q <= 8'hFF;
            for (int unsigned b = 0; b < NB; b++) begin
                act_cnt_q[b] <= 8'hFF;
                pre_cnt_q[b] <= 8'hFF;
            end
            flags_q <= '0;
            count_q <= '0;
            fv_q    <= 1'b0;
            code_q  <= '0;
        end else begin
            open_q    <= open_d;
            ap_q      <= ap_d;
            ref_cnt_q <= ref_cnt_d;
            for (int unsigned b = 0; b < NB; b++) begin
                act_cnt_q[b] <= act_cnt_d[b];
                pre_cnt_q[b] <= pre_cnt_d[b];
            end
            flags_q <= flags_d;
            count_q <= count_d;
            fv_q    <= fv_d;
            code_q  <= code_d;
        end
    end

`ifdef SDRAM_CHECKER_REFRESH_EN
    always_ff @(posedge clk_sys or negedge rst_n_por) begin
        if (!rst_n_por) begin
            timer_q <= '0;
            fired_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            fired_q <= fired_d;
        end
    end
`endif

    assign err_flags       = flags_q;
    assign err_count       = count_q;
    assign first_err_valid = fv_q;
    assign first_err_code  = code_q;

endmodule

// File: tb/tb_sdram_protocol_checker.sv
// Scoreboard bench: a timestamp-based reference model predicts the error outputs per cycle;
// a monitor process compares them one cycle after each command is sampled.
module tb_sdram_protocol_checker;

    localparam int T_RCD     = 2;
    localparam int T_RP      = 2;
    localparam int T_RAS     = 5;
    localparam int T_RFC     = 8;
    localparam int BURST_LEN = 8;
    localparam int T_REFI    = 780;

    localparam logic [2:0] OP_MRS = 3'b000, OP_REF = 3'b001, OP_PRE = 3'b010, OP_ACT = 3'b011,
                           OP_WR  = 3'b100, OP_RD  = 3'b101, OP_NOP = 3'b111;

    logic        clk_sys = 1'b0;
    logic        rst_n_por;
    logic        sdram_clke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic        clr_errors;
    logic [7:0]  err_flags;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [2:0]  first_err_code;

    always #5 clk_sys = ~clk_sys;

    sdram_protocol_checker #(
        .W_BANKSEL(2), .W_ADDR(13), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
        .T_RFC(T_RFC), .BURST_LEN(BURST_LEN), .T_REFI(T_REFI)
    ) dut (
        .clk_sys(clk_sys), .rst_n_por(rst_n_por), .sdram_clke(sdram_clke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
        .clr_errors(clr_errors), .err_flags(err_flags), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_code(first_err_code)
    );

    typedef struct {
        logic [7:0]  flags;
        logic [15:0] count;
        logic        fv;
        logic [2:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: event timestamps instead of counters
    int         now;
    bit         m_open [4];
    bit         m_ap   [4];
    int         t_act  [4];
    int         t_pre  [4];
    int         t_ref;
    int         t_base;
    bit         m_fired;
    logic [7:0] m_flags;
    int         m_count;
    bit         m_fv;
    int         m_code;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        now = 0;
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 0; m_ap[b] = 0; t_act[b] = -1000; t_pre[b] = -1000;
        end
        t_ref = -1000; t_base = 0; m_fired = 0;
        m_flags = 0; m_count = 0; m_fv = 0; m_code = 0;
    endfunction

    function automatic void model_cycle(input int op, input int ba, input bit a10, input bit clr);
        logic [7:0] v = 8'h00;
        bit any_open = 0;
        for (int b = 0; b < 4; b++) any_open |= m_open[b];
        if (op != 7 && now - t_ref < T_RFC) v[6] = 1;
`ifdef SDRAM_CHECKER_REFRESH_EN
        if (!m_fired && now - t_base == T_REFI) begin
            v[7] = 1; m_fired = 1;
        end
`endif
        case (op)
            3: begin
                if (m_open[ba]) v[0] = 1;
                if (now - t_pre[ba] < (m_ap[ba] ? T_RP + BURST_LEN : T_RP)) v[3] = 1;
                m_open[ba] = 1; t_act[ba] = now;
            end
            4, 5: begin
                if (!m_open[ba]) v[1] = 1;
                if (now - t_act[ba] < T_RCD) v[2] = 1;
                if (a10) begin
                    m_open[ba] = 0; t_pre[ba] = now; m_ap[ba] = 1;
                end
            end
            2: begin
                for (int b = 0; b < 4; b++) begin
                    if ((a10 || b == ba) && m_open[b]) begin
                        if (now - t_act[b] < T_RAS) v[4] = 1;
                        m_open[b] = 0; t_pre[b] = now; m_ap[b] = 0;
                    end
                end
            end
            0, 1: begin
                if (any_open) v[5] = 1;
                if (op == 1) begin
                    t_ref = now; t_base = now + 1; m_fired = 0;
                end
            end
            default: ;
        endcase
        if (clr) begin
            m_flags = 0; m_count = 0; m_fv = 0;
        end
        m_flags |= v;
        if (v != 0) begin
            if (m_count < 65535) m_count++;
            if (!m_fv) begin
                m_fv = 1;
                for (int i = 7; i >= 0; i--) if (v[i]) m_code = i;
            end
        end
        now++;
    endfunction

    // Called at a negedge: drive one command, predict its outcome, advance one cycle.
    task automatic step(input bit cke, input bit cs_n, input logic [2:0] op,
                        input logic [1:0] ba, input bit a10, input bit clr);
        exp_t e;
        sdram_clke  = cke;
        sdram_cs_n  = cs_n;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = op;
        sdram_ba    = ba;
        sdram_a     = 13'($urandom);
        sdram_a[10] = a10;
        clr_errors  = clr;
        model_cycle((cke && !cs_n) ? int'(op) : 7, int'(ba), a10, clr);
        e.flags = m_flags; e.count = 16'(m_count); e.fv = m_fv; e.code = 3'(m_code);
        exp_q.push_back(e);
        @(negedge clk_sys);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] ba, input bit a10);
        step(1'b1, 1'b0, op, ba, a10, 1'b0);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, OP_NOP, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic dchk(input string name, input logic [7:0] f, input int c, input bit fv,
                        input int code);
        chk({name, ".flags"}, err_flags, f);
        chk({name, ".count"}, err_count, c);
        chk({name, ".fv"}, first_err_valid, fv);
        if (fv) chk({name, ".code"}, first_err_code, code);
    endtask

    task automatic do_reset();
        #2 rst_n_por = 1'b0;
        sdram_clke = 1'b1; sdram_cs_n = 1'b1;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = OP_NOP;
        clr_errors = 1'b0;
        repeat (3) @(negedge clk_sys);
        dchk("reset", 8'h00, 0, 1'b0, 0);
        chk("reset.code", first_err_code, 0);
        rst_n_por = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb.flags", err_flags, e.flags);
                chk("sb.count", err_count, e.count);
                chk("sb.fv", first_err_valid, e.fv);
                chk("sb.code", first_err_code, e.code);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n_por = 1'b0;
        sdram_a   = '0;
        sdram_ba  = '0;
        model_reset();
        do_reset();

        // ACT then READ exactly T_RCD later: legal
        nop(10); cmd(OP_ACT, 2'd0, 0); nop(1); cmd(OP_RD, 2'd0, 0);
        dchk("s1_rcd_ok", 8'h00, 0, 1'b0, 0);

        do_reset();
        nop(10); cmd(OP_ACT, 2'd1, 0); cmd(OP_WR, 2'd1, 0);
        dchk("s2_rcd_viol", 8'h04, 1, 1'b1, 2);

        do_reset();
        nop(10); cmd(OP_ACT, 2'd2, 0); nop(2); cmd(OP_PRE, 2'd2, 0); cmd(OP_ACT, 2'd2, 0);
        dchk("s3_ras_rp", 8'h18, 2, 1'b1, 4);

        // Auto-precharge extends the ACT lockout to T_RP+BURST_LEN
        do_reset();
        nop(10); cmd(OP_ACT, 2'd3, 0); nop(1); cmd(OP_RD, 2'd3, 1); nop(4); cmd(OP_ACT, 2'd3, 0);
        dchk("s4_ap_early", 8'h08, 1, 1'b1, 3);
        do_reset();
        nop(10); cmd(OP_ACT, 2'd3, 0); nop(1); cmd(OP_RD, 2'd3, 1); nop(9); cmd(OP_ACT, 2'd3, 0);
        dchk("s4_ap_ok", 8'h00, 0, 1'b0, 0);

        do_reset();
        cmd(OP_REF, 2'd0, 0); nop(4); cmd(OP_ACT, 2'd0, 0);
        dchk("s5_rfc", 8'h40, 1, 1'b1, 6);
        step(1'b1, 1'b0, OP_ACT, 2'd0, 1'b0, 1'b1);
        dchk("s5_clr_coincident", 8'h41, 1, 1'b1, 0);

        do_reset();
        nop(780);
        dchk("s6_refi_before", 8'h00, 0, 1'b0, 0);
        nop(1);
`ifdef SDRAM_CHECKER_REFRESH_EN
        dchk("s6_refi_fire", 8'h80, 1, 1'b1, 7);
        nop(20);
        dchk("s6_refi_once", 8'h80, 1, 1'b1, 7);
`else
        dchk("s6_refi_off", 8'h00, 0, 1'b0, 0);
`endif

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            bit         cke, cs_n, a10, clr;
            logic [2:0] op;
            if (i == 1200) do_reset();
            cke  = ($urandom_range(0, 15) != 0);
            cs_n = ($urandom_range(0, 9) == 0);
            a10  = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 19))
                0, 1, 2:    op = OP_ACT;
                3, 4:       op = OP_RD;
                5, 6:       op = OP_WR;
                7, 8:       op = OP_PRE;
                9:          op = ($urandom_range(0, 3) == 0) ? OP_MRS : OP_REF;
                10:         op = 3'b110;
                default:    op = OP_NOP;
            endcase
            step(cke, cs_n, op, 2'($urandom), a10, clr);
        end

        repeat (2) @(negedge clk_sys);
        chk("sb.drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
